// File: rtl/series_sum_seq.sv
// Sequential series accumulator: sums i or i^2 for i = 0..N, one addition per clock,
// with a start/busy/done handshake and a sticky per-operation overflow flag.
module series_sum_seq #(
    parameter int NW = 4,
    parameter int SW = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          mode,
    input  logic [NW-1:0] N,
    output logic [SW-1:0] S,
    output logic          busy,
    output logic          done,
    output logic          ovf
);

    localparam int TW = 2 * NW;
    localparam int XW = ((SW > TW) ? SW : TW) + 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t        state, state_n;
    logic [NW-1:0] nl, nl_n;
    logic [NW-1:0] i, i_n;
    logic          ml, ml_n;
    logic [SW-1:0] acc, acc_n;
    logic [TW-1:0] sq, sq_n;
    logic [TW-1:0] term;
    logic [XW-1:0] sum;
    logic          vf, vf_n;
    logic [SW-1:0] s_n;
    logic          ovf_n;
    logic          done_n;

    assign busy = (state == RUN);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            nl    <= '0;
            ml    <= 1'b0;
            i     <= '0;
            sq    <= '0;
            acc   <= '0;
            vf    <= 1'b0;
            S     <= '0;
            ovf   <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            nl    <= nl_n;
            ml    <= ml_n;
            i     <= i_n;
            sq    <= sq_n;
            acc   <= acc_n;
            vf    <= vf_n;
            S     <= s_n;
            ovf   <= ovf_n;
            done  <= done_n;
        end
    end

    // Widened sum: any bit above SW-1 means this addition wrapped the accumulator.
    always_comb begin
        state_n = state;
        nl_n    = nl;
        ml_n    = ml;
        i_n     = i;
        sq_n    = sq;
        acc_n   = acc;
        vf_n    = vf;
        s_n     = S;
        ovf_n   = ovf;
        done_n  = 1'b0;
        term    = ml ? sq : TW'(i);
        sum     = XW'(acc) + XW'(term);

        case (state)
            IDLE: begin
                if (start) begin
                    nl_n    = N;
                    ml_n    = mode;
                    acc_n   = '0;
                    i_n     = '0;
                    sq_n    = '0;
                    vf_n    = 1'b0;
                    state_n = RUN;
                end
            end
            RUN: begin
                acc_n = sum[SW-1:0];
                vf_n  = vf | (|sum[XW-1:SW]);
                if (i == nl) begin
                    s_n     = acc_n;
                    ovf_n   = vf_n;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else begin
                    // (i+1)^2 = i^2 + 2i + 1; 2i+1 is just i with a 1 appended.
                    i_n  = i + NW'(1);
                    sq_n = sq + TW'({i, 1'b1});
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_series_sum_seq.sv
// Bench for series_sum_seq: a wide-result and a narrow (overflowing) instance run in
// lockstep and are checked against closed-form series sums.
module tb_series_sum_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        mode;
    logic [3:0]  N;

    logic [11:0] s_a;
    logic        busy_a, done_a, ovf_a;
    logic [6:0]  s_b;
    logic        busy_b, done_b, ovf_b;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [31:0] exp_sa, exp_sb;
    logic        exp_oa, exp_ob;

    series_sum_seq #(.NW(4), .SW(12)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .mode  (mode),
        .N     (N),
        .S     (s_a),
        .busy  (busy_a),
        .done  (done_a),
        .ovf   (ovf_a)
    );

    series_sum_seq #(.NW(4), .SW(7)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .mode  (mode),
        .N     (N),
        .S     (s_b),
        .busy  (busy_b),
        .done  (done_b),
        .ovf   (ovf_b)
    );

    always #5 clk = ~clk;

    function automatic longint unsigned series_total(input int n, input bit m);
        longint unsigned ln;
        ln = longint'(n);
        if (m) return ln * (ln + 1) * (2 * ln + 1) / 6;
        return ln * (ln + 1) / 2;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic predict(input int n, input bit m);
        longint unsigned tot;
        tot    = series_total(n, m);
        exp_sa = 32'(tot % 4096);
        exp_oa = (tot >= 4096);
        exp_sb = 32'(tot % 128);
        exp_ob = (tot >= 128);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Starts an operation; afterwards we sit just past t0 with cyc = 0.
    task automatic launch(input int n, input bit m);
        N     = 4'(n);
        mode  = m;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc   = 0;
        check("busy_after_start_a", 32'(busy_a), 32'd1);
        check("busy_after_start_b", 32'(busy_b), 32'd1);
        check("s_held_a", 32'(s_a), exp_sa);
        check("s_held_b", 32'(s_b), exp_sb);
        predict(n, m);
    endtask

    task automatic finish_op(input string tag, input int lat);
        while (done_a !== 1'b1 && cyc < 40) begin
            check({tag, "_busy_run"}, 32'(busy_a), 32'd1);
            step();
        end
        check({tag, "_latency"}, 32'(cyc), 32'(lat));
        check({tag, "_done_b"}, 32'(done_b), 32'd1);
        check({tag, "_s_a"}, 32'(s_a), exp_sa);
        check({tag, "_ovf_a"}, 32'(ovf_a), 32'(exp_oa));
        check({tag, "_s_b"}, 32'(s_b), exp_sb);
        check({tag, "_ovf_b"}, 32'(ovf_b), 32'(exp_ob));
        check({tag, "_busy_clear"}, 32'(busy_a | busy_b), 32'd0);
        step();
        check({tag, "_done_pulse"}, 32'(done_a | done_b), 32'd0);
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        mode   = 1'b0;
        N      = '0;
        exp_sa = 0;
        exp_sb = 0;
        exp_oa = 1'b0;
        exp_ob = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_a", 32'(s_a), 32'd0);
        check("rst_s_b", 32'(s_b), 32'd0);
        check("rst_busy", 32'(busy_a | busy_b), 32'd0);
        check("rst_done", 32'(done_a | done_b), 32'd0);
        check("rst_ovf", 32'(ovf_a | ovf_b), 32'd0);
        rst_n = 1'b1;
        step();

        // Sum of integers, squares at the largest N, then integers at the largest N.
        launch(10, 1'b0);
        finish_op("sum10", 11);
        check("sum10_const", exp_sa, 32'd55);
        launch(15, 1'b1);
        finish_op("sq15", 16);
        check("sq15_ovf_narrow", 32'(ovf_b), 32'd1);
        launch(15, 1'b0);
        finish_op("sum15", 16);
        launch(4, 1'b0);
        finish_op("sum4", 5);

        // N=0, then start held through the done cycle to chain the next operation.
        N     = 4'd0;
        mode  = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        cyc  = 0;
        N    = 4'd3;
        mode = 1'b0;
        predict(0, 1'b1);
        finish_op("min0", 1);
        start = 1'b0;
        cyc   = 0;
        check("chain_busy", 32'(busy_a), 32'd1);
        predict(3, 1'b0);
        finish_op("chain3", 4);

        // start while busy must be dropped.
        launch(8, 1'b0);
        step();
        step();
        start = 1'b1;
        N     = 4'd2;
        mode  = 1'b1;
        step();
        start = 1'b0;
        finish_op("ignore", 9);
        for (int k = 0; k < 6; k++) begin
            step();
            check("ignore_no_extra_done", 32'(done_a | done_b), 32'd0);
        end

        // Reset mid-operation abandons it silently.
        launch(12, 1'b0);
        repeat (4) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("midrst_busy", 32'(busy_a | busy_b), 32'd0);
        check("midrst_s_a", 32'(s_a), 32'd0);
        check("midrst_s_b", 32'(s_b), 32'd0);
        check("midrst_ovf", 32'(ovf_a | ovf_b), 32'd0);
        check("midrst_done", 32'(done_a | done_b), 32'd0);
        exp_sa = 0;
        exp_sb = 0;
        exp_oa = 1'b0;
        exp_ob = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            check("midrst_no_done", 32'(done_a | done_b), 32'd0);
        end
        launch(5, 1'b0);
        finish_op("after_rst", 6);

        // Randomized operations.
        for (int k = 0; k < 24; k++) begin
            int rn;
            bit rm;
            rn = int'($urandom_range(0, 15));
            rm = 1'($urandom_range(0, 1));
            launch(rn, rm);
            finish_op("rand", rn + 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/series_sum_seq.md
# series_sum_seq

Sequential, parametrised series accumulator: on a start pulse it latches an operand N and a mode, then computes either the sum 0+1+…+N or the sum of squares 0²+1²+…+N², using one addition per clock. The result is presented with a done pulse and a sticky overflow flag. It is the clocked, multi-mode successor to the team's combinational sum-of-N block, and it sits behind a simple start/busy/done handshake for use by controller FSMs.

## Interface
- NW, default 4: width of operand N.
- SW, default 12: width of result S. The default holds the worst case 0²+…+15² = 1240.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- start  input  1  request pulse; sampled only in IDLE.
- mode  input  1  0 = sum of i, 1 = sum of i²; latched with start.
- N  input  NW  upper limit of the series (inclusive); latched with start.
- S  output  SW  result of the last completed operation, modulo 2^SW.
- busy  output  1  high while an operation is in progress.
- done  output  1  single-cycle pulse when S is updated.
- ovf  output  1  sticky per operation; set if any addition in the operation exceeded SW bits.

## Operation
- **States:** IDLE and RUN.
- **Reset** (rst_n=0 at a rising edge), regardless of state:
  - state goes to IDLE.
  - S=0, busy=0, done=0, ovf=0.
  - Internal accumulator, index i and latched operands are cleared.
  - An operation in progress is abandoned and produces no done pulse.
- **IDLE, start=1:**
  - Latch N and mode into nl and ml.
  - Clear accumulator acc=0, i=0 and the internal overflow flag.
  - Set busy=1 and go to RUN.
  - S and ovf keep their previous values until completion.
- **IDLE, start=0:** hold; done=0.
- **RUN, each cycle:**
  - Compute acc ← acc + term, with term = i (ml=0) or i² (ml=1).
  - Set the overflow flag if the carry out of bit SW-1 is 1.
  - If i == nl: write S ← updated acc and ovf ← updated overflow flag; pulse done=1; clear busy; go to IDLE.
  - Otherwise: i ← i+1 and stay in RUN.
- **start during RUN** is ignored and is not queued.
- **Arithmetic:**
  - i is NW bits and never wraps, because termination is tested before the increment.
  - i² may be formed incrementally (sq ← sq + 2i + 1), with an internal width of at least 2·NW bits.
  - acc is SW bits and wraps modulo 2^SW. The wrap is reported only through ovf; there is no saturation.
- **N=0:** exactly one RUN cycle; S=0, ovf=0.
- **Back-to-back operations:** a start asserted in the cycle where done=1 is accepted, because the FSM is already in IDLE.

## Timing
- Let t0 be the edge where start is sampled in IDLE.
- **Additions:** occur at edges t1 … t(N+1), one per value of i = 0 … N.
- **Completion:** at edge t(N+1), S and ovf are updated and done rises. done is high for exactly one cycle, until t(N+2).
- **busy:** high from t0 up to t(N+1).
- **Latency:** start to done is N+1 cycles; the minimum is 1 (N=0) and the maximum is 2^NW.
- **Throughput:** a new start may be sampled at t(N+1)'s following edge, giving one operation per N+2 cycles. If start is held high continuously, operations run back to back at one per N+2 cycles.
- **Output stability:** S and ovf change only at a completion edge or at reset.

## Test plan
- **Sum of integers:** reset, then start with N=10, mode=0. Required: busy for 11 cycles, done at t11, S=55, ovf=0.
- **Sum of squares:** start with N=15, mode=1 (defaults). Required: done at t16, S=1240, ovf=0. Then start with N=15, mode=0; required: S=120.
- **Minimum case:** start with N=0, mode=1. Required: done at t1, S=0, ovf=0. Follow with start=1 held through the done cycle with N=3, mode=0; required: second done 4 cycles later, S=6.
- **Overflow:** instance with SW=7; start with N=15, mode=1. Required: S=88 (1240 mod 128), ovf=1. Then start with N=4, mode=0; required: S=10, ovf=0.
- **start ignored while busy:** start with N=8, mode=0; pulse start with N=2, mode=1 at t3. Required: single done at t9 with S=36, no extra done afterwards.
- **Reset mid-operation:** start with N=12, mode=0; assert rst_n=0 at t5 for one cycle. Required: busy=0, S=0, ovf=0 from the next cycle, and no done pulse. A following start with N=5 yields S=15 after 6 cycles.
